dot_field_tracker: RTL

Parametrised Pac-Man dot field: holds a ROWS×COLS pellet map, clears cells as Pac-Man reaches tile-aligned positions, and keeps a serially-computed remaining-dot count, a saturating score and a level-clear indication. It sits between the Pac-Man motion controller (pixel position) and the sprite/render path (per-cell display map), and generalises the fixed 12×12 dot grid.

---
 rtl/dot_field_tracker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dot_field_tracker.sv
// Pac-Man dot field: pellet map, tile-aligned eating, serial dot count, saturating score.
// Optional POWER_PELLET_EN macro adds the power-pellet mask, pellet scoring and pellet_pulse.
module dot_field_tracker #(
  parameter int unsigned COLS          = 12,
  parameter int unsigned ROWS          = 12,
  parameter int unsigned TILE_SHIFT    = 5,
  parameter int unsigned ORIGIN        = 1,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned SCORE_W       = 16,
  parameter int unsigned DOT_POINTS    = 10,
  parameter int unsigned PELLET_POINTS = 50
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   load,
  input  logic [ROWS*COLS-1:0]   init_map,
  input  logic [ROWS*COLS-1:0]   pellet_map,
  input  logic                   score_clr,
  input  logic                   pac_valid,
  input  logic [9:0]             pac_x,
  input  logic [9:0]             pac_y,
  output logic [ROWS*COLS-1:0]   display,
  output logic [CNT_W-1:0]       dots_left,
  output logic                   busy,
  output logic                   eat_pulse,
  output logic                   pellet_pulse,
  output logic [SCORE_W-1:0]     score,
  output logic                   level_clear,
  output logic                   level_clear_pulse
);

  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned IDX_W  = $clog2(CELLS);
  localparam int unsigned POS_W  = 10;
  localparam int unsigned TILE_W = POS_W - TILE_SHIFT;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, CLEAR} state_t;

  state_t             state, state_next;
  logic [CELLS-1:0]   display_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [CNT_W-1:0]   dots_next;
  logic [SCORE_W-1:0] score_next;
  logic               eat_next, pellet_next, lcp_next;
  logic               busy_next, lc_next;

  // Pixel position to grid cell
  logic [TILE_W-1:0]  tile_x, tile_y;
  logic [31:0]        col, row;
  logic               aligned, in_range;
  logic [IDX_W-1:0]   bit_idx;
  logic               eat_hit;
  logic               pellet_hit;
  logic [SCORE_W:0]   score_sum;

  assign tile_x   = pac_x[POS_W-1:TILE_SHIFT];
  assign tile_y   = pac_y[POS_W-1:TILE_SHIFT];
  assign col      = 32'(tile_x) - 32'(ORIGIN);
  assign row      = 32'(tile_y) - 32'(ORIGIN);
  assign aligned  = (pac_x[TILE_SHIFT-1:0] == '0) && (pac_y[TILE_SHIFT-1:0] == '0);
  assign in_range = (32'(tile_x) >= 32'(ORIGIN)) && (col < 32'(COLS)) &&
                    (32'(tile_y) >= 32'(ORIGIN)) && (row < 32'(ROWS));
  assign bit_idx  = IDX_W'((32'(ROWS) - 32'd1 - row) * 32'(COLS) + (32'(COLS) - 32'd1 - col));
  assign eat_hit  = (state == PLAY) && pac_valid && aligned && in_range && display[bit_idx];

`ifdef POWER_PELLET_EN
  logic [CELLS-1:0] pellet_mask, pellet_mask_next;

  assign pellet_hit = pellet_mask[bit_idx];

  // Pellet mask follows the dot map: loaded with it, cleared as cells are eaten
  always_comb begin
    pellet_mask_next = pellet_mask;
    if (load) begin
      pellet_mask_next = pellet_map & init_map;
    end else if (eat_hit) begin
      pellet_mask_next[bit_idx] = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pellet_mask <= '0;
    end else begin
      pellet_mask <= pellet_mask_next;
    end
  end
`else
  logic unused_pellet_map;

  assign unused_pellet_map = ^pellet_map;
  assign pellet_hit        = 1'b0;
`endif

  assign score_sum = {1'b0, score} +
                     (SCORE_W+1)'(pellet_hit ? PELLET_POINTS : DOT_POINTS);

  // Next-state and datapath update
  always_comb begin
    state_next   = state;
    display_next = display;
    idx_next     = idx;
    dots_next    = dots_left;
    score_next   = score;
    eat_next     = 1'b0;
    pellet_next  = 1'b0;
    lcp_next     = 1'b0;

    if (load) begin
      display_next = init_map;
      idx_next     = '0;
      dots_next    = '0;
      state_next   = LOAD;
    end else begin
      case (state)
        LOAD: begin
          dots_next = dots_left + CNT_W'(display[idx]);
          if (idx == IDX_W'(CELLS - 1)) begin
            if (dots_next != '0) begin
              state_next = PLAY;
            end else begin
              state_next = CLEAR;
              lcp_next   = 1'b1;
            end
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
        PLAY: begin
          if (eat_hit) begin
            display_next[bit_idx] = 1'b0;
            dots_next             = dots_left - CNT_W'(1);
            eat_next              = 1'b1;
            pellet_next           = pellet_hit;
            score_next            = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            if (dots_left == CNT_W'(1)) begin
              state_next = CLEAR;
              lcp_next   = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end

    if (score_clr) begin
      score_next = '0;
    end

    busy_next = (state_next == LOAD);
    lc_next   = (state_next == CLEAR);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state             <= IDLE;
      display           <= '0;
      idx               <= '0;
      dots_left         <= '0;
      score             <= '0;
      busy              <= 1'b0;
      eat_pulse         <= 1'b0;
      pellet_pulse      <= 1'b0;
      level_clear       <= 1'b0;
      level_clear_pulse <= 1'b0;
    end else begin
      state             <= state_next;
      display           <= display_next;
      idx               <= idx_next;
      dots_left         <= dots_next;
      score             <= score_next;
      busy              <= busy_next;
      eat_pulse         <= eat_next;
      pellet_pulse      <= pellet_next;
      level_clear       <= lc_next;
      level_clear_pulse <= lcp_next;
    end
  end

endmodule
